zx81_tape_player: RTL and testbench

// Regenerates a ZX81 cassette waveform from a .p image held in the tape buffer RAM.
// It lets ROM LOAD "" run at true speed, as the alternative to the instant-load ROM patch.

---
 rtl/zx81_tape_player.sv | 186 ++++++++++++++++++
 tb/tb_zx81_tape_player.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/zx81_tape_player.sv
// ZX81 cassette waveform generator: replays a .p image from the tape buffer RAM
// as leader silence, name byte, data bytes and trailer silence, at real tape speed.
module zx81_tape_player #(
  parameter int unsigned CLK_HZ    = 52000000,
  parameter int unsigned PULSE_US  = 150,
  parameter int unsigned GAP_US    = 1300,
  parameter int unsigned LEADER_MS = 1000,
  parameter logic [7:0]  NAME_BYTE = 8'hA6,
  parameter bit          INVERT    = 1'b0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic [13:0] tape_size,
  output logic [13:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        tape_out,
  output logic        busy,
  output logic        done,
  output logic [13:0] byte_cnt
);

  localparam int unsigned TICK       = CLK_HZ / 1000000;
  localparam int unsigned LEADER_CYC = LEADER_MS * 1000 * TICK;
  localparam int unsigned PULSE_CYC  = PULSE_US * TICK;
  localparam int unsigned GAP_CYC    = GAP_US * TICK;
  localparam int unsigned MAX_A      = (LEADER_CYC > GAP_CYC) ? LEADER_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC    = (MAX_A > PULSE_CYC) ? MAX_A : PULSE_CYC;
  localparam int          TMR_W      = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] LEADER_LAST = TMR_W'(LEADER_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

  typedef enum logic [3:0] {
    IDLE, LEADER, LOAD_NAME, FETCH, WAIT_RD, PULSE_HI, PULSE_LO, GAP, TRAILER
  } state_t;

  state_t            state_reg, state_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic [3:0]        pulse_cnt_reg, pulse_cnt_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [7:0]        shift_reg, shift_next;
  logic [13:0]       byte_ptr_reg, byte_ptr_next;
  logic [13:0]       size_reg, size_next;
  logic [13:0]       rd_addr_reg, rd_addr_next;
  logic [13:0]       byte_cnt_reg, byte_cnt_next;
  logic              is_data_reg, is_data_next;
  logic              done_reg, done_next;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      pulse_cnt_reg <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      byte_ptr_reg  <= '0;
      size_reg      <= '0;
      rd_addr_reg   <= '0;
      byte_cnt_reg  <= '0;
      is_data_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      pulse_cnt_reg <= pulse_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      byte_ptr_reg  <= byte_ptr_next;
      size_reg      <= size_next;
      rd_addr_reg   <= rd_addr_next;
      byte_cnt_reg  <= byte_cnt_next;
      is_data_reg   <= is_data_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    pulse_cnt_next = pulse_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    byte_ptr_next  = byte_ptr_reg;
    size_next      = size_reg;
    rd_addr_next   = rd_addr_reg;
    byte_cnt_next  = byte_cnt_reg;
    is_data_next   = is_data_reg;
    done_next      = 1'b0;

    if (stop) begin
      state_next     = IDLE;
      timer_next     = '0;
      pulse_cnt_next = '0;
    end else if (!pause) begin
      unique case (state_reg)
        IDLE: begin
          if (start && tape_size != 14'd0) begin
            size_next     = tape_size;
            byte_ptr_next = '0;
            byte_cnt_next = '0;
            timer_next    = '0;
            state_next    = LEADER;
          end
        end
        LEADER: begin
          if (timer_reg == LEADER_LAST) begin
            timer_next = '0;
            state_next = LOAD_NAME;
          end else timer_next = timer_reg + TMR_ONE;
        end
        LOAD_NAME: begin
          shift_next     = NAME_BYTE;
          bit_idx_next   = 3'd7;
          is_data_next   = 1'b0;
          pulse_cnt_next = '0;
          state_next     = PULSE_HI;
        end
        FETCH: state_next = WAIT_RD;
        WAIT_RD: begin
          shift_next     = rd_data;
          bit_idx_next   = 3'd7;
          is_data_next   = 1'b1;
          pulse_cnt_next = '0;
          state_next     = PULSE_HI;
        end
        PULSE_HI: begin
          if (timer_reg == PULSE_LAST) begin
            timer_next = '0;
            state_next = PULSE_LO;
          end else timer_next = timer_reg + TMR_ONE;
        end
        PULSE_LO: begin
          // The MSB of the shift register is always the bit currently on tape.
          if (timer_reg == PULSE_LAST) begin
            timer_next = '0;
            if (pulse_cnt_reg == (shift_reg[7] ? 4'd8 : 4'd3)) begin
              pulse_cnt_next = '0;
              state_next     = GAP;
            end else begin
              pulse_cnt_next = pulse_cnt_reg + 4'd1;
              state_next     = PULSE_HI;
            end
          end else timer_next = timer_reg + TMR_ONE;
        end
        GAP: begin
          if (timer_reg == GAP_LAST) begin
            timer_next = '0;
            if (bit_idx_reg != 3'd0) begin
              bit_idx_next = bit_idx_reg - 3'd1;
              shift_next   = {shift_reg[6:0], 1'b0};
              state_next   = PULSE_HI;
            end else begin
              if (is_data_reg) byte_cnt_next = byte_cnt_reg + 14'd1;
              // Address is presented during FETCH so sync RAM data is ready in WAIT_RD.
              if (byte_ptr_reg < size_reg) begin
                rd_addr_next  = byte_ptr_reg;
                byte_ptr_next = byte_ptr_reg + 14'd1;
                state_next    = FETCH;
              end else state_next = TRAILER;
            end
          end else timer_next = timer_reg + TMR_ONE;
        end
        TRAILER: begin
          if (timer_reg == LEADER_LAST) begin
            timer_next = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else timer_next = timer_reg + TMR_ONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign tape_out = (state_reg == PULSE_HI) ? ~INVERT : INVERT;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign rd_addr  = rd_addr_reg;
  assign byte_cnt = byte_cnt_reg;

endmodule

// File: tb/tb_zx81_tape_player.sv
// Bench for zx81_tape_player: a per-cycle trace model built from byte/pulse rules,
// checked against a normal and an inverted instance, plus literal run statistics.
module tb_zx81_tape_player;

  typedef struct packed {
    logic        o;
    logic        b;
    logic        d;
    logic [13:0] c;
    logic [13:0] a;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n, start, stop, pause;
  logic [13:0] tape_size;
  logic [13:0] rd_addr, rd_addr_inv, byte_cnt, byte_cnt_inv;
  logic [7:0]  rd_data;
  logic        tape_out, busy, done, tape_out_inv, busy_inv, done_inv;
  logic [7:0]  mem [0:15];

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) rd_data <= mem[rd_addr[3:0]];

  zx81_tape_player #(.CLK_HZ(1000000), .PULSE_US(2), .GAP_US(10), .LEADER_MS(1),
                     .NAME_BYTE(8'hA6), .INVERT(1'b0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .tape_size(tape_size), .rd_addr(rd_addr), .rd_data(rd_data), .tape_out(tape_out),
    .busy(busy), .done(done), .byte_cnt(byte_cnt));

  zx81_tape_player #(.CLK_HZ(1000000), .PULSE_US(2), .GAP_US(10), .LEADER_MS(1),
                     .NAME_BYTE(8'hA6), .INVERT(1'b1)) dut_inv (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .tape_size(tape_size), .rd_addr(rd_addr_inv), .rd_data(rd_data), .tape_out(tape_out_inv),
    .busy(busy_inv), .done(done_inv), .byte_cnt(byte_cnt_inv));

  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];
  logic [13:0] model_addr, cur_cnt, cur_addr;
  int          rises, max_hi, busy_cycles, done_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic add(input int n, input logic o, input logic b, input logic d);
    exp_t e;
    e.o = o; e.b = b; e.d = d; e.c = cur_cnt; e.a = cur_addr;
    for (int k = 0; k < n; k++) q.push_back(e);
  endtask

  // One bit = N x (2 high, 2 low) then 10 low; N = 9 for a one, 4 for a zero.
  task automatic add_byte(input logic [7:0] bv);
    for (int i = 7; i >= 0; i--) begin
      for (int p = 0; p < (bv[i] ? 9 : 4); p++) begin
        add(2, 1'b1, 1'b1, 1'b0);
        add(2, 1'b0, 1'b1, 1'b0);
      end
      add(10, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic build(input int size);
    q.delete();
    cur_cnt  = '0;
    cur_addr = model_addr;
    add(1001, 1'b0, 1'b1, 1'b0);
    add_byte(8'hA6);
    for (int k = 0; k < size; k++) begin
      cur_addr = 14'(k);
      add(2, 1'b0, 1'b1, 1'b0);
      add_byte(mem[k]);
      cur_cnt = 14'(k + 1);
    end
    add(1000, 1'b0, 1'b1, 1'b0);
    add(1, 1'b0, 1'b0, 1'b1);
    add(10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cut_at(input int idx);
    exp_t e;
    e = q[idx];
    while (q.size() > idx + 1) void'(q.pop_back());
    cur_cnt  = e.c;
    cur_addr = e.a;
    add(20, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hold_at(input int idx, input int len);
    exp_t e;
    e = q[idx];
    for (int k = 0; k < len; k++) q.insert(idx + 1, e);
  endtask

  task automatic run(input int stop_at, input int pause_at, input int pause_len, input int reset_at);
    exp_t e;
    int   i, hi_run, run_errs;
    logic prev_o;
    i = 0; hi_run = 0; run_errs = 0; prev_o = 1'b0;
    rises = 0; max_hi = 0; busy_cycles = 0; done_count = 0;
    while (i < q.size()) begin
      @(negedge clk_sys);
      start = 1'b0; stop = 1'b0; tape_size = 14'd7;
      e = q[i];
      checks++;
      if ({tape_out, tape_out_inv, busy, done, byte_cnt, rd_addr} !==
          {e.o, ~e.o, e.b, e.d, e.c, e.a}) begin
        errors++; run_errs++;
        $display("FAIL trace[%0d]: got out=%b inv=%b busy=%b done=%b cnt=%0d addr=%0d, want out=%b inv=%b busy=%b done=%b cnt=%0d addr=%0d",
                 i, tape_out, tape_out_inv, busy, done, byte_cnt, rd_addr,
                 e.o, ~e.o, e.b, e.d, e.c, e.a);
      end
      if (tape_out && !prev_o) rises++;
      hi_run = tape_out ? hi_run + 1 : 0;
      if (hi_run > max_hi) max_hi = hi_run;
      prev_o = tape_out;
      busy_cycles += int'(busy);
      done_count  += int'(done);
      if (i == stop_at) stop = 1'b1;
      if (i == pause_at) pause = 1'b1;
      if (pause_at >= 0 && i == pause_at + pause_len) pause = 1'b0;
      if (i == reset_at) begin
        #2 reset_n = 1'b0;
        #1 check("async_reset", {tape_out, tape_out_inv, busy, done, byte_cnt, rd_addr},
                 {1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 14'd0});
        model_addr = '0;
        return;
      end
      if (run_errs >= 20) break;
      i++;
    end
    model_addr = q[q.size() - 1].a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; tape_size = '0;
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    model_addr = '0;
    repeat (3) @(negedge clk_sys);
    check("reset_tape_out", tape_out, 1'b0);
    check("reset_tape_out_inv", tape_out_inv, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_byte_cnt", byte_cnt, 14'd0);
    check("reset_rd_addr", rd_addr, 14'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Single byte 0x80: name + data, full leader/trailer.
    mem[0] = 8'h80;
    build(1);
    tape_size = 14'd1; start = 1'b1;
    run(-1, -1, 0, -1);
    check("t1_busy_cycles", busy_cycles, 2519);
    check("t1_pulses", rises, 89);
    check("t1_high_width", max_hi, 2);
    check("t1_done_pulses", done_count, 1);
    check("t1_byte_cnt", byte_cnt, 14'd1);

    // Zero-size start is ignored.
    @(negedge clk_sys);
    tape_size = 14'd0; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      start = 1'b0;
      check("t3_idle", {busy, tape_out, tape_out_inv}, 3'b001);
    end

    // Three bytes, pulse counts and byte_cnt steps.
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55;
    @(negedge clk_sys);
    build(3);
    tape_size = 14'd3; start = 1'b1;
    run(-1, -1, 0, -1);
    check("t4_busy_cycles", busy_cycles, 3159);
    check("t4_pulses", rises, 208);
    check("t4_done_pulses", done_count, 1);
    check("t4_byte_cnt", byte_cnt, 14'd3);

    // Stop during byte 2.
    @(negedge clk_sys);
    build(3);
    cut_at(1520);
    tape_size = 14'd3; start = 1'b1;
    run(1520, -1, 0, -1);
    check("t5_done_pulses", done_count, 0);
    check("t5_byte_cnt", byte_cnt, 14'd1);

    // start and stop together in IDLE.
    @(negedge clk_sys);
    tape_size = 14'd3; start = 1'b1; stop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      start = 1'b0; stop = 1'b0;
      check("t5_start_stop", {busy, byte_cnt}, {1'b0, 14'd1});
    end

    // Pause for 50 cycles in the first high phase of the data byte.
    mem[0] = 8'h80;
    @(negedge clk_sys);
    build(1);
    hold_at(1291, 50);
    tape_size = 14'd1; start = 1'b1;
    run(-1, 1291, 50, -1);
    check("t6_pause_high_width", max_hi, 52);
    check("t6_pause_busy_cycles", busy_cycles, 2569);
    check("t6_pause_pulses", rises, 89);

    // Asynchronous reset while a pulse is high in byte 2.
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55;
    @(negedge clk_sys);
    build(3);
    tape_size = 14'd3; start = 1'b1;
    run(-1, -1, 0, 1501);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("t6_after_reset", {busy, tape_out, done}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
